axi_addr_decoder: RTL and testbench
===================================

Name: axi_addr_decoder

Overview:
- AXI4-Lite 1-to-2 address decoder, the fan-out counterpart of the 2:1 arbiter.
- One upstream master (typically the arbiter output) is routed to one of two downstream slaves by address: s0 = SRAM/memory, s1 = peripheral/UART region.
- Unmapped addresses go to an internal error responder that completes the transaction with DECERR.
- Read and write paths are independent and each allows one outstanding transaction.

Parameters:
- S0_BASE, 32'h8000_0000, s0 match value.
- S0_MASK, 32'hF800_0000, s0 match mask.
- S1_BASE, 32'hA000_0000, s1 match value.
- S1_MASK, 32'hFFFF_0000, s1 match mask.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-low (0 = reset asserted).
- m  axi_if.slave  bundle  upstream master side: araddr/awaddr 32, wdata/rdata 32, wmask 4, rresp/bresp 2.
- s0  axi_if.master  bundle  downstream slave 0.
- s1  axi_if.master  bundle  downstream slave 1.

Behaviour:
- Decode: target = S0 if (addr & S0_MASK)==S0_BASE, else S1 if (addr & S1_MASK)==S1_BASE, else ERR. S0 has priority if both match.
- The target is latched into rd_sel/wr_sel at the address handshake.
- Reset (reset==0 at posedge): rd_state=RD_IDLE, wr_state=WR_IDLE, sel=ERR.
  - While reset is low, every valid and ready output on all three ports is driven 0.
  - Reset mid-transaction drops any outstanding transaction with no response; downstream slaves share the same reset.
- Read FSM, states RD_IDLE and RD_RESP:
  - RD_IDLE: araddr is forwarded to both slaves. Only the decoded target sees arvalid=m.arvalid; m.arready = target.arready, combinational, zero added latency.
  - ERR target: m.arready=1 in RD_IDLE.
  - AR handshake: latch rd_sel, go to RD_RESP.
  - RD_RESP: all s*.arvalid=0 and m.arready=0. m.rvalid/rdata/rresp are muxed from rd_sel; s[rd_sel].rready = m.rready.
  - ERR response: rvalid=1 in the cycle after the AR handshake, rdata=0, rresp=2'b11.
  - Exit to RD_IDLE on m.rvalid && m.rready. The next AR is accepted no earlier than the following cycle.
- Write FSM, states WR_IDLE, WR_DATA, WR_ADDR, WR_RESP:
  - WR_IDLE: target is decoded from m.awaddr. awvalid is forwarded to the target only.
  - WR_IDLE: wvalid/wdata/wmask are forwarded to the target only while m.awvalid=1. If m.awvalid=0, m.wready=0 (W-before-AW waits).
  - Both AW and W handshakes in the same cycle: go to WR_RESP.
  - AW handshake only: go to WR_DATA.
  - W handshake only: go to WR_ADDR.
  - In all three cases, latch wr_sel.
  - WR_DATA: W is forwarded to s[wr_sel]; AW is blocked. On W handshake go to WR_RESP.
  - WR_ADDR: AW is forwarded to s[wr_sel] (m.awaddr must decode to the same target, which is an AXI stability requirement on the master); W is blocked. On AW handshake go to WR_RESP.
  - ERR target: awready=1 and wready=1 immediately. bvalid=1 from the cycle after entering WR_RESP, bresp=2'b11.
  - WR_RESP: m.bvalid/bresp come from s[wr_sel]; s[wr_sel].bready = m.bready. Exit to WR_IDLE on the B handshake.
- Non-selected slaves always see valid=0 and ready=0.
- Read and write may target the same slave concurrently; no cross-path ordering is enforced.
- Slave-side OKAY/SLVERR resp values pass through unchanged.

Decomposition:
- Package axi_lite_if holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Default address-map constants.
  - enum tgt_t {TGT_S0, TGT_S1, TGT_ERR}.
  - Function decode_addr(addr) returning tgt_t.
- One sub-module is natural: axi_decerr_slave, the error responder with its own 1-deep read/write response FSM. It is instantiated as a third internal target so that the main muxes are uniform 3-way.

Test Plan:
- Read 0x8000_0010; s0 arready=1, rvalid 2 cycles later with rdata 0xDEADBEEF, rresp 00 -> m sees rvalid with 0xDEADBEEF/00; s1.arvalid never 1; m.arready matches s0.arready in the same cycle.
- Write 0xA000_03F8, wdata 0x0000_0041, wmask 4'b0001, AW and W in the same cycle, s1 ready -> s1 sees both in that cycle; bvalid from s1 reaches m; s0 untouched.
- Read 0x0000_1000 (unmapped) -> m.arready=1 the same cycle, m.rvalid=1 next cycle with rdata 0 and rresp 2'b11; no downstream arvalid.
- W before AW: wvalid from cycle 0, awvalid 0x8000_0000 at cycle 3; s0 awready=0 and wready=1 at cycle 3 -> m.wready=0 for cycles 0-2; at cycle 3 W completes and the FSM enters WR_ADDR; AW is forwarded to s0 until awready.
- Backpressure: s0 rvalid held, m.rready=0 for 5 cycles, second m.arvalid pending -> rvalid/rdata stable throughout; s0.arvalid=0 until the R handshake; second AR is accepted the next cycle.
- reset=0 in WR_DATA -> next cycle all valid and ready outputs are 0 and wr_state=WR_IDLE; after release, a fresh write completes normally.

Source files
------------

// File: rtl/axi_addr_decoder_pkg.sv
// Shared AXI4-Lite types for the 1-to-2 address decoder: response codes,
// default address map, target and FSM state encodings, and the decode function.
package axi_lite_if;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_S0_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_S0_MASK = 32'hF800_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'hA000_0000;
    localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_0000;

    // Values double as indices into the 3-way target muxes.
    typedef enum logic [1:0] {TGT_S0 = 2'd0, TGT_S1 = 2'd1, TGT_ERR = 2'd2} tgt_t;

    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_ADDR, WR_RESP} wr_state_t;
    typedef enum logic {DE_RD_IDLE, DE_RD_RESP} de_rd_state_t;
    typedef enum logic [1:0] {DE_WR_IDLE, DE_WR_DATA, DE_WR_ADDR, DE_WR_RESP} de_wr_state_t;

    typedef struct packed {
        rd_state_t    rd;
        wr_state_t    wr;
        de_rd_state_t de_rd;
        de_wr_state_t de_wr;
    } dbg_t;

    // S0 wins when both windows match.
    function automatic tgt_t decode_addr(
        input logic [31:0] addr,
        input logic [31:0] s0_base = DEF_S0_BASE,
        input logic [31:0] s0_mask = DEF_S0_MASK,
        input logic [31:0] s1_base = DEF_S1_BASE,
        input logic [31:0] s1_mask = DEF_S1_MASK
    );
        if ((addr & s0_mask) == s0_base) return TGT_S0;
        if ((addr & s1_mask) == s1_base) return TGT_S1;
        return TGT_ERR;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4-Lite bundle with master/slave views.
// Handshake: a transfer happens on a posedge where valid and ready are both 1;
// valid never waits for ready, and payload is stable while valid is high.
interface axi_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_addr_decoder_decerr.sv
// Internal error responder: accepts any request it is offered and answers
// one transaction per direction with DECERR and zero read data.
module axi_decerr_slave
    import axi_lite_if::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         arvalid_i,
    output logic         arready_o,
    output logic         rvalid_o,
    input  logic         rready_i,
    output logic [31:0]  rdata_o,
    output logic [1:0]   rresp_o,
    input  logic         awvalid_i,
    output logic         awready_o,
    input  logic         wvalid_i,
    output logic         wready_o,
    output logic         bvalid_o,
    input  logic         bready_i,
    output logic [1:0]   bresp_o,
    output de_rd_state_t rd_state_o,
    output de_wr_state_t wr_state_o
);

    de_rd_state_t rd_state_q, rd_state_d;
    de_wr_state_t wr_state_q, wr_state_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_state_q <= DE_RD_IDLE;
            wr_state_q <= DE_WR_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_o  = 1'b0;
        rvalid_o   = 1'b0;
        case (rd_state_q)
            DE_RD_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) rd_state_d = DE_RD_RESP;
            end
            DE_RD_RESP: begin
                rvalid_o = 1'b1;
                if (rready_i) rd_state_d = DE_RD_IDLE;
            end
            default: rd_state_d = DE_RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        awready_o  = 1'b0;
        wready_o   = 1'b0;
        bvalid_o   = 1'b0;
        case (wr_state_q)
            DE_WR_IDLE: begin
                awready_o = 1'b1;
                wready_o  = 1'b1;
                if (awvalid_i && wvalid_i) wr_state_d = DE_WR_RESP;
                else if (awvalid_i)        wr_state_d = DE_WR_DATA;
                else if (wvalid_i)         wr_state_d = DE_WR_ADDR;
            end
            DE_WR_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i) wr_state_d = DE_WR_RESP;
            end
            DE_WR_ADDR: begin
                awready_o = 1'b1;
                if (awvalid_i) wr_state_d = DE_WR_RESP;
            end
            DE_WR_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) wr_state_d = DE_WR_IDLE;
            end
            default: wr_state_d = DE_WR_IDLE;
        endcase
    end

    assign rdata_o    = '0;
    assign rresp_o    = RESP_DECERR;
    assign bresp_o    = RESP_DECERR;
    assign rd_state_o = rd_state_q;
    assign wr_state_o = wr_state_q;

endmodule

// File: rtl/axi_addr_decoder.sv
// AXI4-Lite 1-to-2 address decoder: routes the upstream master to s0, s1 or
// the internal DECERR responder, with one outstanding read and one write.
module axi_addr_decoder
    import axi_lite_if::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S0_MASK = DEF_S0_MASK,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S1_MASK = DEF_S1_MASK
) (
    input  logic  clk,
    input  logic  reset,
    axi_if.slave  m,
    axi_if.master s0,
    axi_if.master s1,
    output dbg_t  dbg_o
);

    rd_state_t rd_state_q, rd_state_d;
    wr_state_t wr_state_q, wr_state_d;
    tgt_t      rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
    tgt_t      rd_tgt, wr_tgt;

    // Per-target vectors, index = tgt_t (s0, s1, error responder).
    logic [2:0]  arvalid_v, arready_v, rvalid_v, rready_v;
    logic [2:0]  awvalid_v, awready_v, w_fwd_v, wready_v, bvalid_v, bready_v;
    logic [31:0] rdata_a [3];
    logic [1:0]  rresp_a [3];
    logic [1:0]  bresp_a [3];

    logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp, m_bresp;
    logic        aw_hs, w_hs;

    de_rd_state_t de_rd_state;
    de_wr_state_t de_wr_state;
    logic         de_arready, de_rvalid, de_awready, de_wready, de_bvalid;
    logic [31:0]  de_rdata;
    logic [1:0]   de_rresp, de_bresp;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_sel_q   <= TGT_ERR;
            wr_sel_q   <= TGT_ERR;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_sel_q   <= rd_sel_d;
            wr_sel_q   <= wr_sel_d;
        end
    end

    assign rd_tgt = decode_addr(m.araddr, S0_BASE, S0_MASK, S1_BASE, S1_MASK);
    assign wr_tgt = decode_addr(m.awaddr, S0_BASE, S0_MASK, S1_BASE, S1_MASK);

    // Everything stays at zero while reset is held, so no stray handshakes.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_sel_d   = rd_sel_q;
        arvalid_v  = '0;
        rready_v   = '0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
        m_rresp    = '0;
        if (reset) begin
            case (rd_state_q)
                RD_IDLE: begin
                    arvalid_v[rd_tgt] = m.arvalid;
                    m_arready         = arready_v[rd_tgt];
                    if (m.arvalid && m_arready) begin
                        rd_sel_d   = rd_tgt;
                        rd_state_d = RD_RESP;
                    end
                end
                RD_RESP: begin
                    m_rvalid            = rvalid_v[rd_sel_q];
                    m_rdata             = rdata_a[rd_sel_q];
                    m_rresp             = rresp_a[rd_sel_q];
                    rready_v[rd_sel_q]  = m.rready;
                    if (m_rvalid && m.rready) rd_state_d = RD_IDLE;
                end
                default: rd_state_d = RD_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_sel_d   = wr_sel_q;
        awvalid_v  = '0;
        w_fwd_v    = '0;
        bready_v   = '0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_bresp    = '0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        if (reset) begin
            case (wr_state_q)
                WR_IDLE: begin
                    awvalid_v[wr_tgt] = m.awvalid;
                    m_awready         = awready_v[wr_tgt];
                    // W is held off until AW shows where it is going.
                    if (m.awvalid) begin
                        w_fwd_v[wr_tgt] = 1'b1;
                        m_wready        = wready_v[wr_tgt];
                    end
                    aw_hs = m.awvalid && m_awready;
                    w_hs  = m.wvalid && m_wready;
                    if (aw_hs || w_hs) wr_sel_d = wr_tgt;
                    if (aw_hs && w_hs) wr_state_d = WR_RESP;
                    else if (aw_hs)    wr_state_d = WR_DATA;
                    else if (w_hs)     wr_state_d = WR_ADDR;
                end
                WR_DATA: begin
                    w_fwd_v[wr_sel_q] = 1'b1;
                    m_wready          = wready_v[wr_sel_q];
                    if (m.wvalid && m_wready) wr_state_d = WR_RESP;
                end
                WR_ADDR: begin
                    awvalid_v[wr_sel_q] = m.awvalid;
                    m_awready           = awready_v[wr_sel_q];
                    if (m.awvalid && m_awready) wr_state_d = WR_RESP;
                end
                WR_RESP: begin
                    m_bvalid           = bvalid_v[wr_sel_q];
                    m_bresp            = bresp_a[wr_sel_q];
                    bready_v[wr_sel_q] = m.bready;
                    if (m_bvalid && m.bready) wr_state_d = WR_IDLE;
                end
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    axi_decerr_slave u_decerr (
        .clk_i      (clk),
        .rst_ni     (reset),
        .arvalid_i  (arvalid_v[TGT_ERR]),
        .arready_o  (de_arready),
        .rvalid_o   (de_rvalid),
        .rready_i   (rready_v[TGT_ERR]),
        .rdata_o    (de_rdata),
        .rresp_o    (de_rresp),
        .awvalid_i  (awvalid_v[TGT_ERR]),
        .awready_o  (de_awready),
        .wvalid_i   (w_fwd_v[TGT_ERR] & m.wvalid),
        .wready_o   (de_wready),
        .bvalid_o   (de_bvalid),
        .bready_i   (bready_v[TGT_ERR]),
        .bresp_o    (de_bresp),
        .rd_state_o (de_rd_state),
        .wr_state_o (de_wr_state)
    );

    assign arready_v  = {de_arready, s1.arready, s0.arready};
    assign rvalid_v   = {de_rvalid, s1.rvalid, s0.rvalid};
    assign awready_v  = {de_awready, s1.awready, s0.awready};
    assign wready_v   = {de_wready, s1.wready, s0.wready};
    assign bvalid_v   = {de_bvalid, s1.bvalid, s0.bvalid};
    assign rdata_a[0] = s0.rdata;
    assign rdata_a[1] = s1.rdata;
    assign rdata_a[2] = de_rdata;
    assign rresp_a[0] = s0.rresp;
    assign rresp_a[1] = s1.rresp;
    assign rresp_a[2] = de_rresp;
    assign bresp_a[0] = s0.bresp;
    assign bresp_a[1] = s1.bresp;
    assign bresp_a[2] = de_bresp;

    assign s0.araddr  = m.araddr;
    assign s1.araddr  = m.araddr;
    assign s0.arvalid = arvalid_v[0];
    assign s1.arvalid = arvalid_v[1];
    assign s0.rready  = rready_v[0];
    assign s1.rready  = rready_v[1];
    assign s0.awaddr  = m.awaddr;
    assign s1.awaddr  = m.awaddr;
    assign s0.awvalid = awvalid_v[0];
    assign s1.awvalid = awvalid_v[1];
    assign s0.wvalid  = w_fwd_v[0] & m.wvalid;
    assign s1.wvalid  = w_fwd_v[1] & m.wvalid;
    assign s0.wdata   = w_fwd_v[0] ? m.wdata : '0;
    assign s1.wdata   = w_fwd_v[1] ? m.wdata : '0;
    assign s0.wmask   = w_fwd_v[0] ? m.wmask : '0;
    assign s1.wmask   = w_fwd_v[1] ? m.wmask : '0;
    assign s0.bready  = bready_v[0];
    assign s1.bready  = bready_v[1];

    assign m.arready  = m_arready;
    assign m.rvalid   = m_rvalid;
    assign m.rdata    = m_rdata;
    assign m.rresp    = m_rresp;
    assign m.awready  = m_awready;
    assign m.wready   = m_wready;
    assign m.bvalid   = m_bvalid;
    assign m.bresp    = m_bresp;

    assign dbg_o = '{rd: rd_state_q, wr: wr_state_q, de_rd: de_rd_state, de_wr: de_wr_state};

endmodule

// File: tb/tb_axi_addr_decoder.sv
// Directed bench for axi_addr_decoder: drives the master and both slaves,
// scoreboards R and B responses, and spot-checks routing and stalls.
module tb_axi_addr_decoder;
  import axi_lite_if::*;

  logic clk = 1'b0;
  logic reset;
  dbg_t dbg;
  int checks = 0;
  int failures = 0;
  logic [33:0] rexp_q[$];
  logic [1:0] bexp_q[$];

  axi_if m_if();
  axi_if s0_if();
  axi_if s1_if();

  axi_addr_decoder dut (
    .clk   (clk),
    .reset (reset),
    .m     (m_if),
    .s0    (s0_if),
    .s1    (s1_if),
    .dbg_o (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_m();
    m_if.araddr = '0; m_if.arvalid = 1'b0; m_if.rready = 1'b0;
    m_if.awaddr = '0; m_if.awvalid = 1'b0; m_if.wdata = '0;
    m_if.wmask = '0; m_if.wvalid = 1'b0; m_if.bready = 1'b0;
  endtask

  task automatic clear_s();
    s0_if.arready = 1'b0; s0_if.rdata = '0; s0_if.rresp = '0; s0_if.rvalid = 1'b0;
    s0_if.awready = 1'b0; s0_if.wready = 1'b0; s0_if.bresp = '0; s0_if.bvalid = 1'b0;
    s1_if.arready = 1'b0; s1_if.rdata = '0; s1_if.rresp = '0; s1_if.rvalid = 1'b0;
    s1_if.awready = 1'b0; s1_if.wready = 1'b0; s1_if.bresp = '0; s1_if.bvalid = 1'b0;
  endtask

  // scoreboard monitor: R and B handshakes pop the expected queues
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_if.rvalid && m_if.rready) begin
        if (rexp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected act=%0h exp=none", {m_if.rdata, m_if.rresp});
        end else begin
          chk("r_beat", {m_if.rdata, m_if.rresp}, rexp_q.pop_front());
        end
      end
      if (m_if.bvalid && m_if.bready) begin
        if (bexp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected act=%0h exp=none", m_if.bresp);
        end else begin
          chk("b_beat", m_if.bresp, bexp_q.pop_front());
        end
      end
    end
  end

  logic [31:0] dec_addr[4] = '{32'h87FF_FFFC, 32'h8800_0000, 32'hA000_FFFC, 32'hA001_0000};
  logic [2:0]  dec_exp[4]  = '{3'b100, 3'b001, 3'b010, 3'b001};

  initial begin
    clear_m();
    clear_s();
    reset = 1'b0;
    cyc();
    cyc();
    // reset: pending requests must not leak through
    m_if.araddr = 32'h8000_0000; m_if.arvalid = 1'b1; s0_if.arready = 1'b1;
    m_if.awaddr = 32'h1000_0000; m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
    #1;
    chk("rst_m_arready", m_if.arready, 1'b0);
    chk("rst_s0_arvalid", s0_if.arvalid, 1'b0);
    chk("rst_m_aw_w_ready", {m_if.awready, m_if.wready}, 2'b00);
    chk("rst_states", {dbg.rd, dbg.wr}, {RD_IDLE, WR_IDLE});
    cyc();
    clear_m(); clear_s();
    reset = 1'b1;

    // decode boundaries, combinational only (arvalid dropped before the edge)
    cyc();
    m_if.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_if.araddr = dec_addr[i];
      #1;
      chk("decode_route", {s0_if.arvalid, s1_if.arvalid, m_if.arready}, dec_exp[i]);
    end
    m_if.arvalid = 1'b0;

    // read from s0
    cyc();
    m_if.araddr = 32'h8000_0010; m_if.arvalid = 1'b1; m_if.rready = 1'b1; s0_if.arready = 1'b1;
    rexp_q.push_back({32'hDEAD_BEEF, RESP_OKAY});
    #1;
    chk("rd1_route", {s0_if.arvalid, s1_if.arvalid}, 2'b10);
    chk("rd1_arready", m_if.arready, 1'b1);
    cyc();
    m_if.arvalid = 1'b0; s0_if.arready = 1'b0;
    #1;
    chk("rd1_state", dbg.rd, RD_RESP);
    cyc();
    s0_if.rvalid = 1'b1; s0_if.rdata = 32'hDEAD_BEEF; s0_if.rresp = RESP_OKAY;
    #1;
    chk("rd1_rready_fwd", {s0_if.rready, s1_if.rready}, 2'b10);
    cyc();
    s0_if.rvalid = 1'b0; m_if.rready = 1'b0;
    #1;
    chk("rd1_idle", dbg.rd, RD_IDLE);

    // write to s1, AW and W together
    cyc();
    m_if.awaddr = 32'hA000_03F8; m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
    m_if.wdata = 32'h0000_0041; m_if.wmask = 4'b0001; m_if.bready = 1'b1;
    s1_if.awready = 1'b1; s1_if.wready = 1'b1;
    bexp_q.push_back(RESP_OKAY);
    #1;
    chk("wr1_s1_fwd", {s1_if.awvalid, s1_if.wvalid, s1_if.wdata, s1_if.wmask}, {2'b11, 32'h41, 4'b0001});
    chk("wr1_s0_quiet", {s0_if.awvalid, s0_if.wvalid}, 2'b00);
    chk("wr1_m_ready", {m_if.awready, m_if.wready}, 2'b11);
    cyc();
    m_if.awvalid = 1'b0; m_if.wvalid = 1'b0; s1_if.awready = 1'b0; s1_if.wready = 1'b0;
    s1_if.bvalid = 1'b1; s1_if.bresp = RESP_OKAY;
    #1;
    chk("wr1_state", dbg.wr, WR_RESP);
    chk("wr1_bready_fwd", {s0_if.bready, s1_if.bready}, 2'b01);
    cyc();
    s1_if.bvalid = 1'b0; m_if.bready = 1'b0;

    // unmapped read
    cyc();
    m_if.araddr = 32'h0000_1000; m_if.arvalid = 1'b1; m_if.rready = 1'b1;
    rexp_q.push_back({32'h0, RESP_DECERR});
    #1;
    chk("rd_err_arready", m_if.arready, 1'b1);
    chk("rd_err_no_fwd", {s0_if.arvalid, s1_if.arvalid}, 2'b00);
    cyc();
    m_if.arvalid = 1'b0;
    #1;
    chk("rd_err_rvalid", m_if.rvalid, 1'b1);
    cyc();
    m_if.rready = 1'b0;
    #1;
    chk("rd_err_idle", {dbg.rd, m_if.rvalid}, {RD_IDLE, 1'b0});

    // W before AW to s0
    m_if.wvalid = 1'b1; m_if.wdata = 32'h1234_5678; m_if.wmask = 4'hF;
    m_if.awaddr = 32'h8000_0000; s0_if.wready = 1'b1; m_if.bready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wfirst_wready_low", {m_if.wready, s0_if.wvalid}, 2'b00);
      cyc();
    end
    m_if.awvalid = 1'b1;
    #1;
    chk("wfirst_c3", {m_if.wready, s0_if.wvalid, m_if.awready, s0_if.awvalid}, 4'b1101);
    cyc();
    m_if.wvalid = 1'b0; s0_if.wready = 1'b0;
    #1;
    chk("wfirst_addr_state", dbg.wr, WR_ADDR);
    chk("wfirst_aw_only", {s0_if.awvalid, s0_if.wvalid, m_if.wready}, 3'b100);
    cyc();
    s0_if.awready = 1'b1;
    bexp_q.push_back(RESP_SLVERR);
    #1;
    chk("wfirst_awready", m_if.awready, 1'b1);
    cyc();
    m_if.awvalid = 1'b0; s0_if.awready = 1'b0;
    s0_if.bvalid = 1'b1; s0_if.bresp = RESP_SLVERR;
    cyc();
    s0_if.bvalid = 1'b0; m_if.bready = 1'b0;
    #1;
    chk("wfirst_idle", dbg.wr, WR_IDLE);

    // read backpressure with a second AR waiting
    cyc();
    m_if.araddr = 32'h8000_0100; m_if.arvalid = 1'b1; s0_if.arready = 1'b1;
    rexp_q.push_back({32'hCAFE_F00D, RESP_OKAY});
    cyc();
    m_if.araddr = 32'h8000_0200;
    s0_if.rvalid = 1'b1; s0_if.rdata = 32'hCAFE_F00D; s0_if.rresp = RESP_OKAY;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_stall", {m_if.rvalid, m_if.rdata, s0_if.arvalid, m_if.arready}, {1'b1, 32'hCAFE_F00D, 2'b00});
      cyc();
    end
    m_if.rready = 1'b1;
    #1;
    chk("bp_release", {s0_if.rready, m_if.arready}, 2'b10);
    cyc();
    s0_if.rvalid = 1'b0;
    rexp_q.push_back({32'h0000_0002, RESP_SLVERR});
    #1;
    chk("bp_second_ar", {s0_if.arvalid, m_if.arready}, 2'b11);
    cyc();
    m_if.arvalid = 1'b0; s0_if.arready = 1'b0;
    s0_if.rvalid = 1'b1; s0_if.rdata = 32'h0000_0002; s0_if.rresp = RESP_SLVERR;
    cyc();
    s0_if.rvalid = 1'b0; m_if.rready = 1'b0;

    // reset while in WR_DATA
    cyc();
    m_if.awaddr = 32'h8000_0040; m_if.awvalid = 1'b1; s0_if.awready = 1'b1;
    cyc();
    m_if.awvalid = 1'b0; s0_if.awready = 1'b0;
    #1;
    chk("rstw_data_state", dbg.wr, WR_DATA);
    reset = 1'b0; m_if.wvalid = 1'b1; s0_if.wready = 1'b1;
    #1;
    chk("rstw_gated", {m_if.wready, s0_if.wvalid}, 2'b00);
    cyc();
    #1;
    chk("rstw_idle", dbg.wr, WR_IDLE);
    chk("rstw_outputs", {m_if.arready, m_if.rvalid, m_if.awready, m_if.wready, m_if.bvalid,
                         s0_if.arvalid, s0_if.awvalid, s0_if.wvalid, s0_if.rready, s0_if.bready,
                         s1_if.arvalid, s1_if.awvalid, s1_if.wvalid, s1_if.rready, s1_if.bready}, 15'h0);
    reset = 1'b1; clear_m(); clear_s();

    // fresh write to s0 after reset
    cyc();
    m_if.awaddr = 32'h8000_0080; m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
    m_if.wdata = 32'h5555_AAAA; m_if.wmask = 4'b1100; m_if.bready = 1'b1;
    s0_if.awready = 1'b1; s0_if.wready = 1'b1;
    bexp_q.push_back(RESP_OKAY);
    #1;
    chk("post_rst_fwd", {s0_if.awvalid, s0_if.wvalid, s0_if.wmask}, {2'b11, 4'b1100});
    cyc();
    m_if.awvalid = 1'b0; m_if.wvalid = 1'b0; s0_if.awready = 1'b0; s0_if.wready = 1'b0;
    s0_if.bvalid = 1'b1; s0_if.bresp = RESP_OKAY;
    cyc();
    s0_if.bvalid = 1'b0;

    // unmapped write completes internally with DECERR
    cyc();
    m_if.awaddr = 32'h1000_0000; m_if.awvalid = 1'b1; m_if.wvalid = 1'b1;
    bexp_q.push_back(RESP_DECERR);
    #1;
    chk("wr_err_ready", {m_if.awready, m_if.wready}, 2'b11);
    chk("wr_err_no_fwd", {s0_if.awvalid, s1_if.awvalid, s0_if.wvalid, s1_if.wvalid}, 4'b0000);
    cyc();
    m_if.awvalid = 1'b0; m_if.wvalid = 1'b0;
    #1;
    chk("wr_err_bvalid", {m_if.bvalid, m_if.bresp}, {1'b1, RESP_DECERR});
    cyc();
    m_if.bready = 1'b0;
    #1;
    chk("wr_err_idle", dbg.wr, WR_IDLE);

    cyc();
    cyc();
    chk("r_queue_drained", rexp_q.size(), 0);
    chk("b_queue_drained", bexp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
